tcm_arb_ram: RTL

Parameterised tightly-coupled memory shared by an instruction-fetch port and a data port over one single-port storage array. It is the next generation of the single-port byte-enabled ITCM. It adds configurable width and depth, a selectable write mode, an optional output register, and a per-port req/gnt/rsp handshake with round-robin arbitration. It sits between the soft-core fetch/LSU units and on-chip block RAM.

---
 rtl/tcm_arb_ram.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tcm_arb_ram.sv
// Shared tightly-coupled memory: fetch port A (read-only) and data port B
// arbitrated round-robin onto one byte-enabled single-port array.
module tcm_arb_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int WRITE_MODE = 0,
  parameter int OUTPUT_REG = 0,
  localparam int BE_WIDTH  = DATA_WIDTH / BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_gnt,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [BE_WIDTH-1:0]   b_be,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  localparam int DEPTH          = 2 ** ADDR_WIDTH;
  localparam int WM_NORMAL      = 0;
  localparam int WM_TRANSPARENT = 1;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [BE_WIDTH-1:0]   be,
    input logic [DATA_WIDTH-1:0] new_word
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) w[i*BYTE_SIZE +: BYTE_SIZE] = new_word[i*BYTE_SIZE +: BYTE_SIZE];
    end
    return w;
  endfunction

  prio_e                 prio;
  logic                  acc_p0;
  logic                  wr_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  vld_p1;
  logic                  port_b_p1;
  logic                  we_p1;
  logic [BE_WIDTH-1:0]   be_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [DATA_WIDTH-1:0] rd_p1;
  logic [DATA_WIDTH-1:0] word_p1;
  logic                  a_upd_p1;
  logic                  b_vld_p1;
  logic                  b_upd_p1;

  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;

  // Stage p0: combinational arbitration; grants are gated off while in reset
  assign a_gnt   = rst_n && a_req && (!b_req || prio == PRIO_A);
  assign b_gnt   = rst_n && b_req && (!a_req || prio == PRIO_B);
  assign acc_p0  = a_gnt || b_gnt;
  assign wr_p0   = b_gnt && b_we;
  assign addr_p0 = b_gnt ? b_addr : a_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_B;
    end else if (a_req && b_req) begin
      prio <= (prio == PRIO_B) ? PRIO_A : PRIO_B;
    end
  end

  // Array: synchronous read returns the pre-write word, per-lane write enables
  always_ff @(posedge clk) begin
    if (acc_p0) rd_p1 <= mem[addr_p0];
    if (wr_p0) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (b_be[i]) mem[b_addr][i*BYTE_SIZE +: BYTE_SIZE] <= b_wdata[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_p0) begin
      be_p1    <= b_be;
      wdata_p1 <= b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      port_b_p1 <= 1'b0;
      we_p1     <= 1'b0;
    end else begin
      vld_p1    <= acc_p0;
      port_b_p1 <= b_gnt;
      we_p1     <= wr_p0;
    end
  end

  // Stage p1: form the response word and decide which port's data updates
  assign word_p1  = (we_p1 && WRITE_MODE == WM_TRANSPARENT) ?
                    merge_lanes(rd_p1, be_p1, wdata_p1) : rd_p1;
  assign a_upd_p1 = vld_p1 && !port_b_p1;
  assign b_vld_p1 = vld_p1 && port_b_p1;
  assign b_upd_p1 = b_vld_p1 && !(we_p1 && WRITE_MODE == WM_NORMAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_upd_p1) a_rdata_q <= word_p1;
      if (b_upd_p1) b_rdata_q <= word_p1;
    end
  end

  // Stage p2: optional output register; without it the held word is bypassed
  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic a_vld_p2;
      logic b_vld_p2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_vld_p2 <= 1'b0;
          b_vld_p2 <= 1'b0;
        end else begin
          a_vld_p2 <= a_upd_p1;
          b_vld_p2 <= b_vld_p1;
        end
      end

      assign a_rsp_valid = a_vld_p2;
      assign b_rsp_valid = b_vld_p2;
      assign a_rdata     = a_rdata_q;
      assign b_rdata     = b_rdata_q;
    end else begin : g_noreg
      assign a_rsp_valid = a_upd_p1;
      assign b_rsp_valid = b_vld_p1;
      assign a_rdata     = a_upd_p1 ? word_p1 : a_rdata_q;
      assign b_rdata     = b_upd_p1 ? word_p1 : b_rdata_q;
    end
  endgenerate

endmodule
